// File: rtl/seq_detector_moore_param.sv
// Runtime-programmable serial pattern detector (Moore output) with a saturating match counter.
// Reset defaults give an overlapping "1001" detector.
module seq_detector_moore_param #(
  parameter int                 MAX_LEN       = 8,
  parameter int                 LEN_W         = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W         = 8,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0000_1001),
  parameter int                 RESET_LEN     = 4,
  parameter bit                 RESET_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic [LEN_W-1:0]   cfg_len_c;

  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], din};
    fill_n = (fill >= len) ? len : fill + LEN_W'(1);
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    // Only the low len bits of history and pattern take part in the compare.
    hit       = (len != '0) && (fill_n == len) && ((hist_n & mask) == (pat & mask));
    cfg_len_c = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      pat         <= RESET_PATTERN;
      len         <= LEN_W'(RESET_LEN);
      ovl         <= RESET_OVERLAP;
      match       <= 1'b0;
      match_count <= '0;
    end else if (cfg_load) begin
      pat   <= cfg_pattern;
      len   <= cfg_len_c;
      ovl   <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
      if (count_clear) match_count <= '0;
    end else begin
      if (din_valid) begin
        hist  <= hist_n;
        fill  <= (hit && !ovl) ? '0 : fill_n;
        match <= hit;
      end else begin
        match <= 1'b0;
      end
      // A hit on the clearing edge counts as the first match after the clear.
      if (count_clear) begin
        match_count <= (din_valid && hit) ? CNT_W'(1) : '0;
      end else if (din_valid && hit && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Bench for seq_detector_moore_param: bit-queue reference model feeding an expected-result scoreboard.
module tb_seq_detector_moore_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               count_clear = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;

  seq_detector_moore_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clear(count_clear),
    .match(match), .match_count(match_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // expected {match, match_count} per accepted edge
  logic [CNT_W:0] exp_q[$];

  // reference model: received bits kept as a queue, oldest first
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = 8'b0000_1001;
    m_len = 4;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din_valid = 1'b0; cfg_load = 1'b0; count_clear = 1'b0;
    @(posedge clk); #1;
    check("reset_match", {7'd0, match}, 8'd0);
    check("reset_count", 8'(match_count), 8'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // driver: one clock edge with the given inputs; scoreboard pop/compare after the edge
  task automatic step(input logic d, input logic v, input logic l, input logic c,
                      input logic [7:0] p, input logic [LEN_W-1:0] ln, input logic o);
    bit hit;
    logic [CNT_W:0] e;
    din = d; din_valid = v; cfg_load = l; count_clear = c;
    cfg_pattern = p; cfg_len = ln; cfg_overlap = o;
    hit = 1'b0;
    if (l) begin
      m_pat = p;
      m_len = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
      m_ovl = o;
      m_bits.delete();
      if (c) m_cnt = 0;
    end else begin
      if (v) begin
        m_bits.push_back(d);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        if (m_len != 0 && m_bits.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit && !m_ovl) m_bits.delete();
      end
      if (c) m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
    end
    exp_q.push_back({hit, CNT_W'(m_cnt)});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("match", {7'd0, match}, {7'd0, e[CNT_W]});
    check("count", 8'(match_count), 8'(e[CNT_W-1:0]));
    din_valid = 1'b0; cfg_load = 1'b0; count_clear = 1'b0;
  endtask

  task automatic bit_in(input logic d);
    step(d, 1'b1, 1'b0, 1'b0, 8'd0, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] ln, input logic o);
    step(1'b0, 1'b0, 1'b1, 1'b0, p, ln, o);
  endtask

  // sends n bits of s, bit [n-1] first
  task automatic stream(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(s[i]);
  endtask

  initial begin
    model_reset();
    #2;

    // default 1001 overlapping
    do_reset();
    stream(32'b1001001, 7);
    check("dflt_total", 8'(match_count), 8'd2);

    // 1001 non-overlapping
    do_reset();
    load(8'b1001, 4'd4, 1'b0);
    stream(32'b1001001, 7);
    check("novl_total", 8'(match_count), 8'd1);

    // 11 overlapping: three consecutive matches
    do_reset();
    load(8'b11, 4'd2, 1'b1);
    stream(32'b1111, 4);
    check("ovl11_total", 8'(match_count), 8'd3);

    // 11 non-overlapping
    do_reset();
    load(8'b11, 4'd2, 1'b0);
    stream(32'b1111, 4);
    check("novl11_total", 8'(match_count), 8'd2);

    // gap in din_valid holds history
    do_reset();
    stream(32'b10, 2);
    repeat (3) idle();
    stream(32'b01, 2);
    check("gap_total", 8'(match_count), 8'd1);

    // saturation, then clear coincident with a hit
    do_reset();
    bit_in(1'b1);
    repeat (20) stream(32'b001, 3);
    check("sat_total", 8'(match_count), 8'(CNT_MAX));
    bit_in(1'b0); bit_in(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, '0, 1'b0);
    check("clr_hit", 8'(match_count), 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, '0, 1'b0);
    check("clr_nohit", 8'(match_count), 8'd0);
    stream(32'b01, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'b1001, 4'd4, 1'b1);
    check("clr_load", 8'(match_count), 8'd0);

    // reset mid-stream discards partial history
    do_reset();
    stream(32'b100, 3);
    do_reset();
    bit_in(1'b1);
    check("rst_partial", {7'd0, match}, 8'd0);
    stream(32'b1001, 4);
    check("rst_full", 8'(match_count), 8'd1);

    // len 0 disables detection
    do_reset();
    load(8'd0, 4'd0, 1'b1);
    repeat (30) bit_in(1'($urandom_range(0, 1)));
    check("len0_total", 8'(match_count), 8'd0);

    // len 1 matches every bit equal to pat[0]
    do_reset();
    load(8'b1111_1110, 4'd1, 1'b1);
    repeat (10) bit_in(1'($urandom_range(0, 1)));

    // oversize length clamps to MAX_LEN
    do_reset();
    load(8'b1011_0011, 4'(MAX_LEN + 3), 1'b1);
    stream(32'b1011_0011, 8);
    check("clamp_hit", 8'(match_count), 8'd1);
    repeat (40) bit_in(1'($urandom_range(0, 1)));

    // random traffic with random configuration changes
    do_reset();
    for (int r = 0; r < 300; r++) begin
      case ($urandom_range(0, 19))
        0:       load(8'($urandom_range(0, 255)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        1:       step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 8'd0, '0, 1'b0);
        2, 3:    idle();
        default: bit_in(1'($urandom_range(0, 1)));
      endcase
    end

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
